// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and the LSU, with tagged 1-cycle responses.
// Optional conflict counter enabled by defining ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_if_req,
    input  logic [ADDR_W-1:0]    i_if_addr,
    output logic                 o_if_stall,
    output logic                 o_if_valid,
    output logic [WIDTH-1:0]     o_if_rdata,
    input  logic                 i_ls_req,
    input  logic                 i_ls_wren,
    input  logic [ADDR_W-1:0]    i_ls_addr,
    input  logic [WIDTH-1:0]     i_ls_wdata,
    input  logic [WIDTH/8-1:0]   i_ls_be,
    output logic                 o_ls_stall,
    output logic                 o_ls_valid,
    output logic [WIDTH-1:0]     o_ls_rdata,
    output logic                 o_mem_en,
    output logic                 o_mem_we,
    output logic [ADDR_W-1:0]    o_mem_addr,
    output logic [WIDTH-1:0]     o_mem_wdata,
    output logic [WIDTH/8-1:0]   o_mem_be,
    input  logic [WIDTH-1:0]     i_mem_rdata,
    output logic [31:0]          o_conflict_cnt
);

    localparam int BYTES = WIDTH / 8;

    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_IF,
        TAG_LS,
        TAG_LS_ST
    } tag_t;

    tag_t       tag;
    logic [3:0] starve;
    logic       fetch_forced;
    logic       gnt_ls;
    logic       gnt_if;

    // LSU wins by default; a fetch denied STARVE_MAX cycles in a row takes the port once.
    assign fetch_forced = i_if_req && (starve == 4'(STARVE_MAX));
    assign gnt_ls       = i_ls_req && !fetch_forced;
    assign gnt_if       = i_if_req && !gnt_ls;

    assign o_if_stall = i_if_req && !gnt_if;
    assign o_ls_stall = i_ls_req && !gnt_ls;

    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_be    = '0;
        if (gnt_ls) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_ls_wren;
            o_mem_addr  = i_ls_addr;
            o_mem_wdata = i_ls_wren ? i_ls_wdata : '0;
            o_mem_be    = i_ls_wren ? i_ls_be : {BYTES{1'b1}};
        end else if (gnt_if) begin
            o_mem_en   = 1'b1;
            o_mem_addr = i_if_addr;
            o_mem_be   = {BYTES{1'b1}};
        end
    end

    // The tag follows the grant every cycle, so the RAM's 1-cycle read data is routed to its owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag    <= TAG_NONE;
            starve <= 4'd0;
        end else begin
            if (gnt_ls)
                tag <= i_ls_wren ? TAG_LS_ST : TAG_LS;
            else if (gnt_if)
                tag <= TAG_IF;
            else
                tag <= TAG_NONE;

            if (i_if_req && !gnt_if)
                starve <= (starve == 4'(STARVE_MAX)) ? starve : starve + 4'd1;
            else
                starve <= 4'd0;
        end
    end

    assign o_if_valid = (tag == TAG_IF);
    assign o_ls_valid = (tag == TAG_LS) || (tag == TAG_LS_ST);
    assign o_if_rdata = (tag == TAG_IF) ? i_mem_rdata : '0;
    assign o_ls_rdata = (tag == TAG_LS) ? i_mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            conflict_cnt <= 32'd0;
        else if (i_if_req && i_ls_req)
            conflict_cnt <= conflict_cnt + 32'd1;
    end

    assign o_conflict_cnt = conflict_cnt;
`else
    assign o_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a byte-enabled synchronous RAM model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_stall, if_valid;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic        ls_wren = 1'b0;
    logic [15:0] ls_addr = '0;
    logic [31:0] ls_wdata = '0;
    logic [3:0]  ls_be = '0;
    logic        ls_stall, ls_valid;
    logic [31:0] ls_rdata;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic [31:0] conflict_cnt;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] ram [0:16383];

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(32), .ADDR_W(16), .STARVE_MAX(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_stall(if_stall), .o_if_valid(if_valid), .o_if_rdata(if_rdata),
        .i_ls_req(ls_req), .i_ls_wren(ls_wren), .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata), .i_ls_be(ls_be),
        .o_ls_stall(ls_stall), .o_ls_valid(ls_valid), .o_ls_rdata(ls_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_be(mem_be), .i_mem_rdata(mem_rdata),
        .o_conflict_cnt(conflict_cnt)
    );

    // Every word holds its byte address + 0x100, except 0x2004 which starts cleared.
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = 32'(i * 4) + 32'h100;
        ram[16'h2004 >> 2] = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr[15:2]][8*b +: 8] = mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[15:2]];
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic ifr, input logic [15:0] ifa,
                                  input logic lsr, input logic lsw, input logic [15:0] lsa,
                                  input logic [31:0] lsd, input logic [3:0] lsb);
        @(negedge clk);
        if_req = ifr; if_addr = ifa;
        ls_req = lsr; ls_wren = lsw; ls_addr = lsa; ls_wdata = lsd; ls_be = lsb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0]  starve_gnt_if;
    logic [11:0] conf_pat;
    int          exp_conflicts;

    initial begin
        $display("[TB] start");
        // Reset state, with stall still combinational while reset is held.
        if_req = 1'b1; ls_req = 1'b1;
        #2;
        check_output("rst_if_stall", 32'(if_stall), 32'd1);
        check_output("rst_ls_stall", 32'(ls_stall), 32'd0);
        if_req = 1'b0; ls_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_if_valid", 32'(if_valid), 32'd0);
        check_output("rst_ls_valid", 32'(ls_valid), 32'd0);
        check_output("rst_conflict_cnt", conflict_cnt, 32'd0);
        check_output("rst_mem_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fetch-only stream.
        apply_stimulus(1, 16'h0000, 0, 0, 16'h0, 32'h0, 4'h0);
        check_output("t1_if_stall", 32'(if_stall), 32'd0);
        check_output("t1_mem_en", 32'(mem_en), 32'd1);
        check_output("t1_mem_we", 32'(mem_we), 32'd0);
        check_output("t1_mem_be", 32'(mem_be), 32'hf);
        tick();
        check_output("t1_if_valid0", 32'(if_valid), 32'd1);
        check_output("t1_if_rdata0", if_rdata, 32'h100);
        apply_stimulus(1, 16'h0004, 0, 0, 16'h0, 32'h0, 4'h0);
        check_output("t1_mem_addr1", 32'(mem_addr), 32'h4);
        tick();
        check_output("t1_if_rdata1", if_rdata, 32'h104);
        apply_stimulus(1, 16'h0008, 0, 0, 16'h0, 32'h0, 4'h0);
        tick();
        check_output("t1_if_rdata2", if_rdata, 32'h108);
        check_output("t1_ls_valid", 32'(ls_valid), 32'd0);
        apply_stimulus(0, 16'h0, 0, 0, 16'h0, 32'h0, 4'h0);
        check_output("idle_mem_en", 32'(mem_en), 32'd0);
        check_output("idle_mem_be", 32'(mem_be), 32'd0);
        check_output("idle_if_stall", 32'(if_stall), 32'd0);
        tick();
        check_output("idle_if_valid", 32'(if_valid), 32'd0);
        check_output("idle_if_rdata", if_rdata, 32'd0);

        // Conflict for one cycle: LSU wins, fetch follows without a bubble.
        apply_stimulus(1, 16'h000c, 1, 0, 16'h2000, 32'h0, 4'h0);
        check_output("t2_if_stall", 32'(if_stall), 32'd1);
        check_output("t2_ls_stall", 32'(ls_stall), 32'd0);
        check_output("t2_mem_addr", 32'(mem_addr), 32'h2000);
        tick();
        check_output("t2_ls_valid", 32'(ls_valid), 32'd1);
        check_output("t2_ls_rdata", ls_rdata, 32'h2100);
        check_output("t2_if_valid0", 32'(if_valid), 32'd0);
        apply_stimulus(1, 16'h000c, 0, 0, 16'h0, 32'h0, 4'h0);
        check_output("t2_if_stall1", 32'(if_stall), 32'd0);
        check_output("t2_mem_addr1", 32'(mem_addr), 32'hc);
        tick();
        check_output("t2_if_valid1", 32'(if_valid), 32'd1);
        check_output("t2_if_rdata", if_rdata, 32'h10c);
        check_output("t2_ls_valid1", 32'(ls_valid), 32'd0);
        check_output("t2_ls_rdata1", ls_rdata, 32'd0);

        // Both requests held 10 cycles: fetch forced on cycles 4 and 9.
        starve_gnt_if = 10'b10_0001_0000;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1, 16'h0010, 1, 0, 16'h2000, 32'h0, 4'h0);
            check_output($sformatf("t3_if_stall%0d", i), 32'(if_stall), 32'(!starve_gnt_if[i]));
            check_output($sformatf("t3_ls_stall%0d", i), 32'(ls_stall), 32'(starve_gnt_if[i]));
            tick();
            check_output($sformatf("t3_if_valid%0d", i), 32'(if_valid), 32'(starve_gnt_if[i]));
            check_output($sformatf("t3_rdata%0d", i), starve_gnt_if[i] ? if_rdata : ls_rdata,
                         starve_gnt_if[i] ? 32'h110 : 32'h2100);
        end

        // Partial store, then read back.
        apply_stimulus(0, 16'h0, 1, 1, 16'h2004, 32'hdeadbeef, 4'b0011);
        check_output("t4_mem_en", 32'(mem_en), 32'd1);
        check_output("t4_mem_we", 32'(mem_we), 32'd1);
        check_output("t4_mem_be", 32'(mem_be), 32'h3);
        check_output("t4_mem_wdata", mem_wdata, 32'hdeadbeef);
        check_output("t4_mem_addr", 32'(mem_addr), 32'h2004);
        tick();
        check_output("t4_ls_valid", 32'(ls_valid), 32'd1);
        check_output("t4_ls_rdata", ls_rdata, 32'd0);
        check_output("t4_if_valid", 32'(if_valid), 32'd0);
        apply_stimulus(0, 16'h0, 1, 0, 16'h2004, 32'h0, 4'h0);
        check_output("t4_ld_we", 32'(mem_we), 32'd0);
        check_output("t4_ld_be", 32'(mem_be), 32'hf);
        check_output("t4_ld_wdata", mem_wdata, 32'd0);
        tick();
        check_output("t4_ld_rdata", ls_rdata, 32'h0000beef);

        // Reset with a load response pending and the fetch partly starved.
        apply_stimulus(1, 16'h0014, 1, 0, 16'h2000, 32'h0, 4'h0);
        tick();
        tick();
        tick();
        check_output("t5_pending_valid", 32'(ls_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_rst_ls_valid", 32'(ls_valid), 32'd0);
        check_output("t5_rst_ls_rdata", ls_rdata, 32'd0);
        check_output("t5_rst_if_stall", 32'(if_stall), 32'd1);
        @(posedge clk);
        #1;
        check_output("t5_rst_ls_valid2", 32'(ls_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("t5_if_stall%0d", i), 32'(if_stall), 32'(i != 4));
            tick();
            check_output($sformatf("t5_ls_valid%0d", i), 32'(ls_valid), 32'(i != 4));
            @(negedge clk);
            #1;
        end
        apply_stimulus(0, 16'h0, 0, 0, 16'h0, 32'h0, 4'h0);
        tick();
        check_output("t5_idle_ls_valid", 32'(ls_valid), 32'd0);
        check_output("t5_idle_if_valid", 32'(if_valid), 32'd0);

        // Conflict counter: 7 conflict cycles among 12.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        conf_pat = 12'b1011_0101_0011;
        for (int i = 0; i < 12; i++) begin
            if (conf_pat[i])
                apply_stimulus(1, 16'h0020, 1, 0, 16'h2000, 32'h0, 4'h0);
            else if (i % 2 == 0)
                apply_stimulus(1, 16'h0020, 0, 0, 16'h0, 32'h0, 4'h0);
            else
                apply_stimulus(0, 16'h0, 1, 0, 16'h2000, 32'h0, 4'h0);
            tick();
        end
        apply_stimulus(0, 16'h0, 0, 0, 16'h0, 32'h0, 4'h0);
        tick();
`ifdef ARB_PERF_CNT_EN
        exp_conflicts = 7;
`else
        exp_conflicts = 0;
`endif
        check_output("t6_conflict_cnt", conflict_cnt, 32'(exp_conflicts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
